// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART receiver, start/MSB-first data/even parity/stop; UART_RX_MAJORITY_EN enables 2-of-3 bit voting
module uart_rx #(
  parameter int C_CLK_FRQ         = 100_000_000,
  parameter int C_UART_RATE       = 1_000_000,
  parameter int C_UART_DATA_WIDTH = 8,
  parameter int C_UART_PARITY     = 1,
  parameter int C_UART_STOP       = 1
) (
  input  logic                         clk,
  input  logic                         rstb,
  input  logic                         rx,
  output logic [C_UART_DATA_WIDTH-1:0] data,
  output logic                         valid,
  output logic                         parity_err,
  output logic                         frame_err,
  output logic                         busy
);

  localparam int C_PERIOD = C_CLK_FRQ / C_UART_RATE;
`ifdef UART_RX_MAJORITY_EN
  // Voting needs the sample one cycle after the centre, so every decision shifts by one.
  localparam int C_OFFS = 1;
`else
  localparam int C_OFFS = 0;
`endif
  localparam int C_HALF     = C_PERIOD / 2 + C_OFFS;
  localparam int C_CNT_W    = $clog2(C_PERIOD + 1);
  localparam int C_BITS_MAX = (C_UART_DATA_WIDTH > C_UART_STOP) ? C_UART_DATA_WIDTH : C_UART_STOP;
  localparam int C_BIT_W    = $clog2(C_BITS_MAX + 1);

  localparam logic [C_CNT_W-1:0] halfLast = C_CNT_W'(C_HALF - 1);
  localparam logic [C_CNT_W-1:0] fullLast = C_CNT_W'(C_PERIOD - 1);
  localparam logic [C_BIT_W-1:0] dataLast = C_BIT_W'(C_UART_DATA_WIDTH - 1);

  typedef enum logic [2:0] {sIDLE, sSTART, sDATA, sPARITY, sSTOP, sRECOVER} state_t;

  state_t                         state;
  state_t                         stateNext;
  logic                           rxMeta;
  logic                           rxs;
  logic                           bitVal;
  logic [C_CNT_W-1:0]             periodCnt;
  logic [C_BIT_W-1:0]             bitCnt;
  logic [C_UART_DATA_WIDTH-1:0]   shiftReg;
  logic [C_UART_DATA_WIDTH-1:0]   wordNow;
  logic [C_UART_DATA_WIDTH:0]     wordExt;
  logic                           parPend;
  logic                           frmAcc;
  logic                           parErrNow;
  logic                           frmErrNow;
  logic                           sampleNow;
  logic                           complete;

  // Two-flop synchronizer; idles high so reset never looks like a start edge.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      rxMeta <= 1'b1;
      rxs    <= 1'b1;
    end else begin
      rxMeta <= rx;
      rxs    <= rxMeta;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  logic rxd1;
  logic rxd2;

  // Short history of rxs so the bit decision sees centre-1, centre and centre+1.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      rxd1 <= 1'b1;
      rxd2 <= 1'b1;
    end else begin
      rxd1 <= rxs;
      rxd2 <= rxd1;
    end
  end

  assign bitVal = (rxs & rxd1) | (rxs & rxd2) | (rxd1 & rxd2);
`else
  assign bitVal = rxs;
`endif

  assign busy = (state != sIDLE);

  // State register.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) state <= sIDLE;
    else       state <= stateNext;
  end

  // Next state, sample strobes and the values a completing frame would publish.
  always_comb begin
    stateNext = state;
    sampleNow = 1'b0;
    complete  = 1'b0;
    parErrNow = parPend;
    frmErrNow = frmAcc;
    wordExt   = {shiftReg, bitVal};
    wordNow   = shiftReg;
    case (state)
      sIDLE: begin
        if (!rxs) stateNext = sSTART;
      end
      sSTART: begin
        if (periodCnt == halfLast) begin
          sampleNow = 1'b1;
          stateNext = bitVal ? sIDLE : sDATA;
        end
      end
      sDATA: begin
        if (periodCnt == fullLast) begin
          sampleNow = 1'b1;
          wordNow   = wordExt[C_UART_DATA_WIDTH-1:0];
          if (bitCnt == dataLast) begin
            if (C_UART_PARITY == 1) stateNext = sPARITY;
            else if (C_UART_STOP > 0) stateNext = sSTOP;
            else begin
              complete  = 1'b1;
              stateNext = sIDLE;
            end
          end
        end
      end
      sPARITY: begin
        if (periodCnt == fullLast) begin
          sampleNow = 1'b1;
          parErrNow = bitVal ^ (^shiftReg);
          if (C_UART_STOP > 0) stateNext = sSTOP;
          else begin
            complete  = 1'b1;
            stateNext = sIDLE;
          end
        end
      end
      sSTOP: begin
        if (periodCnt == fullLast) begin
          sampleNow = 1'b1;
          frmErrNow = frmAcc | ~bitVal;
          if (int'(bitCnt) == C_UART_STOP - 1) begin
            complete  = 1'b1;
            stateNext = frmErrNow ? sRECOVER : sIDLE;
          end
        end
      end
      sRECOVER: begin
        if (rxs) stateNext = sIDLE;
      end
      default: stateNext = sIDLE;
    endcase
  end

  // Counters, shift register, error accumulators and the published frame results.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      periodCnt  <= '0;
      bitCnt     <= '0;
      shiftReg   <= '0;
      parPend    <= 1'b0;
      frmAcc     <= 1'b0;
      data       <= '0;
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      valid <= complete;
      if (state == sIDLE || state == sRECOVER || sampleNow) periodCnt <= '0;
      else periodCnt <= periodCnt + C_CNT_W'(1);
      if (stateNext != state) bitCnt <= '0;
      else if (sampleNow)     bitCnt <= bitCnt + C_BIT_W'(1);
      if (state == sDATA && sampleNow) shiftReg <= wordNow;
      if (state == sIDLE) begin
        parPend <= 1'b0;
        frmAcc  <= 1'b0;
      end else if (sampleNow) begin
        parPend <= parErrNow;
        frmAcc  <= frmErrNow;
      end
      if (complete) begin
        data       <= wordNow;
        parity_err <= (C_UART_PARITY == 1) ? parErrNow : 1'b0;
        frame_err  <= (C_UART_STOP > 0) ? frmErrNow : 1'b0;
      end
    end
  end

endmodule
